cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Parametrised line-transfer arbiter between NUM_CH cache miss channels (I-cache, D-cache, later prefetch or DMA) and the single-ported block RAM. It replaces the fixed I/D pairing of the current cache manager with round-robin arbitration, atomic writeback-then-fill transactions for dirty victims, and per-channel completion pulses. It sits between the cache arrays and the RAM controller, and speaks the existing ram_en/ram_ready line protocol.

## Interface
- NUM_CH, 2: number of requesting channels (≥2); channel 0 is the I-cache.
- ADDR_W, 30: word-address width, matching the RAM address port.
- LINE_W, 256: line width in bits.
- clk  in  1  cache clock
- rst  in  1  reset: asynchronous, active-high
- ch_req  in  NUM_CH  per-channel request; held high until that channel's ch_done
- ch_wb  in  NUM_CH  the request carries a dirty victim to write back first
- ch_fill_addr  in  NUM_CH*ADDR_W  line fill address per channel (flat, ch0 in LSBs)
- ch_wb_addr  in  NUM_CH*ADDR_W  victim address per channel
- ch_wb_line  in  NUM_CH*LINE_W  victim data per channel
- ch_done  out  NUM_CH  one-cycle completion pulse, one-hot
- ch_line_out  out  LINE_W  filled line; valid while ch_done is high
- grant_id  out  $clog2(NUM_CH)  channel currently served
- busy  out  1  a transaction is in progress (state ≠ IDLE)
- status  out  3  debug state encoding
- ram_ready  in  1  RAM completes the current command
- block_from_ram  in  LINE_W  read line, valid with ram_ready
- ram_en_out  out  1  RAM command valid
- ram_write_out  out  1  1 = write command, 0 = read command
- ram_addr_out  out  ADDR_W  command address
- line_wb_out  out  LINE_W  write data

## Operation
- States and status encoding: IDLE=0, WB=1, GAP=2, FILL=3, DONE=4.
- IDLE: if any ch_req is high, grant the winner, latch grant_id, and go to WB when ch_wb[grant] is high, else to FILL.
- Round-robin search starts at last_grant+1 mod NUM_CH. last_grant updates when the grant is made.
- WB: ram_en_out=1, ram_write_out=1, ram_addr_out=ch_wb_addr[grant], line_wb_out=ch_wb_line[grant]. ram_ready moves the block to GAP.
- GAP: one cycle with ram_en_out=0, then go to FILL.
- FILL: ram_en_out=1, ram_write_out=0, ram_addr_out=ch_fill_addr[grant]. On ram_ready, capture block_from_ram into the ch_line_out register and go to DONE.
- DONE: ch_done[grant]=1 for exactly this cycle, then go to IDLE.
- Command outputs are registered from state and grant. They stay stable for the whole WB or FILL state, whatever the RAM latency.
- ram_ready is ignored in IDLE, GAP and DONE.
- Requests that arrive while busy wait for the next IDLE. They are never dropped.
- A channel deasserting ch_req mid-transaction is a protocol violation. The transaction still completes and ch_done still pulses.
- ch_wb and all addresses and data are sampled from the granted channel only, and are read live during WB and FILL. Requesters hold them stable.

## Timing
- Reset values: state=IDLE, last_grant=NUM_CH-1 (so channel 0 wins first), grant_id=0, all ch_done=0, ch_line_out=0, ram_en_out=0, ram_write_out=0, ram_addr_out=0, line_wb_out=0, busy=0, status=0.
- Reset mid-transaction: RAM outputs drop immediately. The pending transaction is abandoned with no ch_done. Requesters re-issue.
- Fill-only latency: req sampled in cycle 0, ram_en_out high from cycle 1. With ram_ready in cycle 1, ch_done pulses in cycle 2.
- Writeback+fill latency: minimum 4 cycles from grant to ch_done (WB, GAP, FILL, DONE), plus RAM wait cycles.
- ram_en_out is always low for at least one cycle between consecutive commands (GAP or DONE→IDLE).
- Requester rule: drop ch_req at the clock edge that ends the ch_done cycle. The next IDLE cycle then sees the updated request vector.
- Back-to-back rule: a different pending channel is granted in the IDLE cycle right after DONE.

## Structure
- Package cache_mem_pkg holds:
  - state localparams (IDLE..DONE, 3 bits);
  - the default LINE_W/ADDR_W constants shared with the cache top.
- Sub-module rr_arbiter (NUM_CH parameter) holds:
  - request vector in, one-hot grant and index out;
  - internal last_grant pointer, updated on an enable pulse.
- The top holds the FSM, the flat-bus slicing muxes and the ch_line_out register.

## Test plan
- Single fill: ch_req=01, fill_addr=0x100, RAM ready after 3 cycles with 0xA5… -> ram_addr_out=0x100, ram_write_out=0; ch_done=01 one cycle later, ch_line_out=0xA5….
- Dirty miss: ch1 req with ch_wb=1, wb_addr=0x200, fill_addr=0x300 -> write to 0x200 carrying wb_line, one-cycle ram_en gap, read of 0x300; ch_done=10 exactly once.
- Contention: ch0 and ch1 held high continuously -> grants alternate 0,1,0,1. After reset the first grant goes to ch0.
- NUM_CH=4 rotation: requests on ch1 and ch3 after a ch3 grant -> next grant is ch1, then ch3.
- Reset during WB with ram_en high -> ram_en_out=0 asynchronously, status=0, no ch_done. After reset a re-issued request completes normally.
- Spurious ram_ready in IDLE and GAP -> no state change, no ch_done.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared types and default widths for the cache line-transfer arbiter.
package cache_mem_pkg;

  // Default widths shared with the cache top level
  localparam int DEFAULT_ADDR_W = 30;
  localparam int DEFAULT_LINE_W = 256;

  // Transaction states; the encoding is also the debug status value
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_GAP  = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last granted
// channel, wrapping around; the pointer only moves on update_en.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              update_en,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic             found;
  logic [IDX_W-1:0] idx;
  int               cand;

  // Search requesters starting one past the last grant
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    cand    = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      idx = IDX_W'(cand);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt[gnt_idx] = found;
  end

  // Pointer advances to the granted channel only when the grant is taken
  always_comb begin
    last_d = last_q;
    if (update_en) begin
      last_d = gnt_idx;
    end
  end

  // Pointer register; reset to the last channel so channel 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(NUM_CH - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Line-transfer arbiter between cache miss channels and the single-ported
// block RAM: round-robin grant, optional writeback before fill, one-cycle
// completion pulse to the served channel.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = DEFAULT_ADDR_W,
  parameter  int LINE_W = DEFAULT_LINE_W,
  localparam int GNT_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wb,
  input  logic [NUM_CH*ADDR_W-1:0] ch_fill_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wb_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wb_line,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [LINE_W-1:0]        ch_line_out,
  output logic [GNT_W-1:0]         grant_id,
  output logic                     busy,
  output logic [2:0]               status,
  input  logic                     ram_ready,
  input  logic [LINE_W-1:0]        block_from_ram,
  output logic                     ram_en_out,
  output logic                     ram_write_out,
  output logic [ADDR_W-1:0]        ram_addr_out,
  output logic [LINE_W-1:0]        line_wb_out
);

  state_e             state_q, state_d;
  logic [GNT_W-1:0]   grant_q, grant_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_write_q, ram_write_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [LINE_W-1:0]  line_wb_q, line_wb_d;
  logic [LINE_W-1:0]  line_out_q, line_out_d;

  logic               arb_en;
  logic [NUM_CH-1:0]  arb_gnt;
  logic [GNT_W-1:0]   arb_idx;
  logic               win_wb;

  logic [ADDR_W-1:0]  fill_addr_arr [NUM_CH];
  logic [ADDR_W-1:0]  wb_addr_arr   [NUM_CH];
  logic [LINE_W-1:0]  wb_line_arr   [NUM_CH];

  // Split the flat per-channel buses so the granted channel can be indexed
  for (genvar c = 0; c < NUM_CH; c++) begin : g_slice
    assign fill_addr_arr[c] = ch_fill_addr[c*ADDR_W +: ADDR_W];
    assign wb_addr_arr[c]   = ch_wb_addr[c*ADDR_W +: ADDR_W];
    assign wb_line_arr[c]   = ch_wb_line[c*LINE_W +: LINE_W];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (ch_req),
    .update_en (arb_en),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx)
  );

  assign win_wb = |(ch_wb & arb_gnt);

  // Next state, grant capture and fill-line capture
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    line_out_d = line_out_q;
    arb_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|ch_req) begin
          arb_en  = 1'b1;
          grant_d = arb_idx;
          state_d = win_wb ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        if (ram_ready) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (ram_ready) begin
          line_out_d = block_from_ram;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM command registers follow the state being entered, so the command
  // is valid for the whole WB or FILL state and drops in GAP/DONE/IDLE
  always_comb begin
    ram_en_d    = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    line_wb_d   = line_wb_q;
    case (state_d)
      ST_WB: begin
        ram_en_d    = 1'b1;
        ram_write_d = 1'b1;
        ram_addr_d  = wb_addr_arr[grant_d];
        line_wb_d   = wb_line_arr[grant_d];
      end
      ST_FILL: begin
        ram_en_d    = 1'b1;
        ram_addr_d  = fill_addr_arr[grant_d];
      end
      default: begin
        ram_en_d    = 1'b0;
      end
    endcase
  end

  // State and command registers; reset abandons any transaction at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      line_wb_q   <= '0;
      line_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ram_en_q    <= ram_en_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      line_wb_q   <= line_wb_d;
      line_out_q  <= line_out_d;
    end
  end

  // Completion pulse to the served channel for the single DONE cycle
  always_comb begin
    ch_done = '0;
    if (state_q == ST_DONE) begin
      ch_done[grant_q] = 1'b1;
    end
  end

  assign ch_line_out   = line_out_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign status        = state_q;
  assign ram_en_out    = ram_en_q;
  assign ram_write_out = ram_write_q;
  assign ram_addr_out  = ram_addr_q;
  assign line_wb_out   = line_wb_q;

endmodule
